serial_subtractor: RTL and testbench

//   Parametrised bit-serial subtractor. It computes diff = a - b - bin over WIDTH

---
 rtl/serial_subtractor.sv | 138 +++++++++++++
 tb/tb_serial_subtractor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor: diff = a - b - bin, computed LSB first over WIDTH
//   cycles through one full-subtractor cell and a registered borrow.
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous reset, active-high; discards any operation in flight
//   start  request, sampled only while idle
//   a, b   minuend / subtrahend, captured when start is accepted
//   bin    borrow-in, captured when start is accepted
//   busy   high while bits are being processed
//   done   one-cycle pulse when diff/bout/ovf carry a new result
//   diff   registered difference, held until the next result
//   bout   borrow out of the MSB (unsigned a < b + bin)
//   ovf    two's complement overflow of a - b - bin
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    counter_reg, counter_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] res_reg, res_next;
  logic [WIDTH-1:0] diff_reg, diff_next;
  logic             borrow_reg, borrow_next;
  logic             bout_reg, bout_next;
  logic             ovf_reg, ovf_next;

  // Full-subtractor cell on the current bit
  logic a_bit, b_bit, d_bit, br_out;

  assign a_bit  = a_reg[counter_reg];
  assign b_bit  = b_reg[counter_reg];
  assign d_bit  = a_bit ^ b_bit ^ borrow_reg;
  assign br_out = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      counter_reg <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      res_reg     <= '0;
      diff_reg    <= '0;
      borrow_reg  <= 1'b0;
      bout_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      res_reg     <= res_next;
      diff_reg    <= diff_next;
      borrow_reg  <= borrow_next;
      bout_reg    <= bout_next;
      ovf_reg     <= ovf_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    res_next     = res_reg;
    diff_next    = diff_reg;
    borrow_next  = borrow_reg;
    bout_next    = bout_reg;
    ovf_next     = ovf_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next       = a;
          b_next       = b;
          borrow_next  = bin;
          counter_next = '0;
          state_next   = SHIFT;
        end
      end

      SHIFT: begin
        // Result bits enter at the MSB so that after WIDTH shifts the first
        // (LSB) bit has arrived at position 0.
        res_next     = {d_bit, res_reg[WIDTH-1:1]};
        borrow_next  = br_out;
        counter_next = counter_reg + CW'(1);
        if (counter_reg == LAST_BIT) begin
          diff_next    = {d_bit, res_reg[WIDTH-1:1]};
          bout_next    = br_out;
          // Borrow into the MSB differs from borrow out of it exactly when
          // the signed result does not fit.
          ovf_next     = borrow_reg ^ br_out;
          counter_next = '0;
          state_next   = DONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state_reg == SHIFT);
  assign done = (state_reg == DONE);
  assign diff = diff_reg;
  assign bout = bout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed and random checks of serial_subtractor at WIDTH = 2, 8 and 32.
//   Three instances share the operand buses; each has its own start line.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_bus, b_bus;
  logic        bin_bus;
  logic        start2, start8, start32;

  logic        busy2, done2, bout2, ovf2;
  logic [1:0]  diff2;
  logic        busy8, done8, bout8, ovf8;
  logic [7:0]  diff8;
  logic        busy32, done32, bout32, ovf32;
  logic [31:0] diff32;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a_bus[1:0]), .b(b_bus[1:0]),
    .bin(bin_bus), .busy(busy2), .done(done2), .diff(diff2), .bout(bout2), .ovf(ovf2)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a_bus[7:0]), .b(b_bus[7:0]),
    .bin(bin_bus), .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(a_bus), .b(b_bus),
    .bin(bin_bus), .busy(busy32), .done(done32), .diff(diff32), .bout(bout32), .ovf(ovf32)
  );

  function automatic logic done_of(input int w);
    case (w)
      2:       return done2;
      8:       return done8;
      default: return done32;
    endcase
  endfunction

  // Issue one operation on the instance of width w; lat counts cycles from
  // the start cycle to the done cycle (bounded).
  task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                        input logic bi, output logic [31:0] d, output logic bo,
                        output logic ov, output int lat);
    @(negedge clk);
    a_bus   = av;
    b_bus   = bv;
    bin_bus = bi;
    case (w)
      2:       start2  = 1'b1;
      8:       start8  = 1'b1;
      default: start32 = 1'b1;
    endcase
    @(negedge clk);
    start2  = 1'b0;
    start8  = 1'b0;
    start32 = 1'b0;
    lat = 1;
    while (done_of(w) !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    case (w)
      2:       begin d = {30'b0, diff2}; bo = bout2;  ov = ovf2;  end
      8:       begin d = {24'b0, diff8}; bo = bout8;  ov = ovf8;  end
      default: begin d = diff32;         bo = bout32; ov = ovf32; end
    endcase
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    start2  = 1'b0;
    start8  = 1'b0;
    start32 = 1'b0;
    a_bus   = '0;
    b_bus   = '0;
    bin_bus = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy8 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy8); else passed++;
    checks++; if (done8 !== 1'b0) $display("FAIL reset_done: got %b expected 0", done8); else passed++;
    checks++; if (diff8 !== 8'h00) $display("FAIL reset_diff: got %h expected 00", diff8); else passed++;
    checks++; if ({bout8, ovf8} !== 2'b00) $display("FAIL reset_bout_ovf: got %b expected 00", {bout8, ovf8}); else passed++;
    checks++;
    if ({busy2, done2, diff2, bout2, ovf2, busy32, done32, diff32, bout32, ovf32} !== '0)
      $display("FAIL reset_other_widths: got diff2=%h diff32=%h busy2=%b busy32=%b expected all zero",
               diff2, diff32, busy2, busy32);
    else passed++;
    rst = 1'b0;
    $display("reset: outputs busy=%b done=%b diff=%h bout=%b ovf=%b", busy8, done8, diff8, bout8, ovf8);
  endtask

  task automatic test_timing();
    int bad_cycle = 0;
    @(negedge clk);
    a_bus = 32'h5A; b_bus = 32'h23; bin_bus = 1'b0; start8 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) start8 = 1'b0;
      if ((busy8 !== 1'b1 || done8 !== 1'b0 || diff8 !== 8'h00) && bad_cycle == 0) bad_cycle = k;
    end
    checks++; if (bad_cycle != 0) $display("FAIL shift_window: got busy=%b done=%b diff=%h at cycle %0d expected busy=1 done=0 diff=00", busy8, done8, diff8, bad_cycle); else passed++;
    @(negedge clk);
    checks++; if ({done8, busy8} !== 2'b10) $display("FAIL done_cycle9: got done=%b busy=%b expected done=1 busy=0", done8, busy8); else passed++;
    checks++; if (diff8 !== 8'h37) $display("FAIL diff_5a_23: got %h expected 37", diff8); else passed++;
    checks++; if ({bout8, ovf8} !== 2'b00) $display("FAIL flags_5a_23: got %b expected 00", {bout8, ovf8}); else passed++;
    $display("op 5a-23-0 -> diff=%h bout=%b ovf=%b", diff8, bout8, ovf8);
    @(negedge clk);
    checks++; if (done8 !== 1'b0) $display("FAIL done_pulse_width: got %b expected 0", done8); else passed++;
  endtask

  task automatic test_borrow_ovf();
    logic [7:0] va [4] = '{8'h00, 8'h80, 8'h10, 8'h7F};
    logic [7:0] vb [4] = '{8'h01, 8'h01, 8'h10, 8'hFF};
    logic       vi [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] ed [4] = '{8'hFF, 8'h7F, 8'hFF, 8'h80};
    logic       eb [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic       eo [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] d;
    logic        bo, ov;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      run_op(8, {24'b0, va[i]}, {24'b0, vb[i]}, vi[i], d, bo, ov, lat);
      $display("op %h-%h-%b -> diff=%h bout=%b ovf=%b latency=%0d", va[i], vb[i], vi[i], d[7:0], bo, ov, lat);
      checks++; if (lat != 9) $display("FAIL latency_%0d: got %0d expected 9", i, lat); else passed++;
      checks++; if (d[7:0] !== ed[i]) $display("FAIL diff_%0d: got %h expected %h", i, d[7:0], ed[i]); else passed++;
      checks++; if (bo !== eb[i]) $display("FAIL bout_%0d: got %b expected %b", i, bo, eb[i]); else passed++;
      checks++; if (ov !== eo[i]) $display("FAIL ovf_%0d: got %b expected %b", i, ov, eo[i]); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va  [4] = '{8'h5A, 8'h10, 8'h00, 8'h33};
    logic [7:0] vb  [4] = '{8'h23, 8'h01, 8'h01, 8'h11};
    logic [7:0] exp [3] = '{8'h37, 8'h0F, 8'hFF};
    logic [7:0] held = 8'h00;
    bit period_ok = 1'b1;
    bit stable_ok = 1'b1;
    @(negedge clk);
    a_bus = {24'b0, va[0]}; b_bus = {24'b0, vb[0]}; bin_bus = 1'b0; start8 = 1'b1;
    for (int t = 1; t <= 29; t++) begin
      @(negedge clk);
      // Operands change during SHIFT; the op in flight must ignore this.
      if (t % 10 == 1) begin
        a_bus = {24'b0, va[t / 10 + 1]};
        b_bus = {24'b0, vb[t / 10 + 1]};
      end
      if ((done8 === 1'b1) != (t % 10 == 9)) period_ok = 1'b0;
      if (t % 10 == 9) begin
        checks++;
        if (diff8 !== exp[t / 10]) $display("FAIL b2b_diff_%0d: got %h expected %h", t / 10, diff8, exp[t / 10]);
        else passed++;
        $display("b2b op %0d -> diff=%h done_cycle=%0d", t / 10, diff8, t);
        held = diff8;
      end else if (t > 9 && diff8 !== held) begin
        stable_ok = 1'b0;
      end
    end
    start8 = 1'b0;
    checks++; if (!period_ok) $display("FAIL b2b_done_period: got irregular done expected pulse every 10 cycles"); else passed++;
    checks++; if (!stable_ok) $display("FAIL b2b_diff_stable: got diff changing between pulses expected held"); else passed++;
  endtask

  task automatic test_reset_mid_op();
    bit no_done = 1'b1;
    logic [31:0] d;
    logic        bo, ov;
    int          lat;
    @(negedge clk);
    a_bus = 32'h5A; b_bus = 32'h23; bin_bus = 1'b0; start8 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start8 = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({busy8, done8} !== 2'b00) $display("FAIL midrst_busy_done: got %b expected 00", {busy8, done8}); else passed++;
    checks++; if (diff8 !== 8'h00) $display("FAIL midrst_diff: got %h expected 00", diff8); else passed++;
    checks++; if ({bout8, ovf8} !== 2'b00) $display("FAIL midrst_flags: got %b expected 00", {bout8, ovf8}); else passed++;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 !== 1'b0 || busy8 !== 1'b0) no_done = 1'b0;
    end
    checks++; if (!no_done) $display("FAIL midrst_no_done: got activity after reset expected idle"); else passed++;
    run_op(8, 32'hC3, 32'h5A, 1'b1, d, bo, ov, lat);
    $display("op c3-5a-1 after reset -> diff=%h bout=%b ovf=%b", d[7:0], bo, ov);
    // c3 - 5a - 1 = 0x68; signed -61 - 90 - 1 = -152 overflows
    checks++; if ({lat == 9, d[7:0], bo, ov} !== {1'b1, 8'h68, 1'b0, 1'b1})
      $display("FAIL midrst_next_op: got lat=%0d diff=%h bout=%b ovf=%b expected lat=9 diff=68 bout=0 ovf=1", lat, d[7:0], bo, ov);
    else passed++;
  endtask

  task automatic test_random(input int w);
    logic [31:0] mask, av, bv, d, exp_d;
    logic [32:0] full;
    logic        bi, bo, ov, exp_bo, exp_ov;
    longint      sa, sb, r, lim;
    int          lat;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    lim  = longint'(1) << (w - 1);
    for (int n = 0; n < 1000; n++) begin
      av = $urandom & mask;
      bv = $urandom & mask;
      bi = 1'($urandom_range(0, 1));
      full   = {1'b0, av} - {1'b0, bv} - {32'b0, bi};
      exp_d  = full[31:0] & mask;
      exp_bo = full[w];
      sa = av[w-1] ? longint'(av) - (longint'(1) << w) : longint'(av);
      sb = bv[w-1] ? longint'(bv) - (longint'(1) << w) : longint'(bv);
      r  = sa - sb - longint'(bi);
      exp_ov = (r > lim - 1) || (r < -lim);
      run_op(w, av, bv, bi, d, bo, ov, lat);
      $display("w%0d op %h-%h-%b -> diff=%h bout=%b ovf=%b", w, av, bv, bi, d, bo, ov);
      checks++;
      if (lat != w + 1 || d !== exp_d || bo !== exp_bo || ov !== exp_ov)
        $display("FAIL rand_w%0d_%0d: got lat=%0d diff=%h bout=%b ovf=%b expected lat=%0d diff=%h bout=%b ovf=%b",
                 w, n, lat, d, bo, ov, w + 1, exp_d, exp_bo, exp_ov);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_borrow_ovf();
    test_back_to_back();
    test_reset_mid_op();
    test_random(2);
    test_random(8);
    test_random(32);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
